// File: rtl/line_buf_3x3_pkg.sv
// Shared filter constants: pixel width, default line capacity, 3x3 tap layout.
// Latency: none (constants, types and helpers only).
// Backpressure: none.
package line_buf_3x3_pkg;

    localparam int LB_DATA_W    = 8;     // default luma sample width
    localparam int LB_MAX_WIDTH = 2048;  // default stored pixels per line
    localparam int LINE_LEN_W   = 12;    // line length counter / report width

    // Window tap index k = r*3 + c; r=0 is row y-2, c=0 is column x-2.
    localparam int TAP_R0C0 = 0;
    localparam int TAP_R0C1 = 1;
    localparam int TAP_R0C2 = 2;
    localparam int TAP_R1C0 = 3;
    localparam int TAP_R1C1 = 4;
    localparam int TAP_R1C2 = 5;
    localparam int TAP_R2C0 = 6;
    localparam int TAP_R2C1 = 7;
    localparam int TAP_R2C2 = 8;

    typedef enum logic {
        BLANK  = 1'b0,
        ACTIVE = 1'b1
    } line_state_t;

    // Per-pixel control carried from the RAM-read cycle to the window update.
    typedef struct packed {
        logic vld;      // pixel accepted into the active line
        logic first;    // first pixel of the line: clear older columns
        logic wr_en;    // pixel lies inside the stored line width
        logic mask_r0;  // force row y-2 tap to zero
        logic mask_r1;  // force row y-1 tap to zero
    } s1_ctrl_t;

    function automatic logic [LINE_LEN_W-1:0] sat_inc(input logic [LINE_LEN_W-1:0] v);
        return (&v) ? v : v + LINE_LEN_W'(1);
    endfunction

endpackage

// File: rtl/line_ram.sv
// One line of pixel storage: simple dual-port, synchronous read, read-first.
// Latency: read data 1 cycle after address; write lands on the same edge.
// Backpressure: none; one read and one write accepted every cycle.
//
// Ports: clk; rd_addr -> rd_dat (registered); wr_en/wr_addr/wr_dat.
// Contents are deliberately not reset.
module line_ram #(
    parameter int DEPTH  = 2048,
    parameter int DATA_W = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_dat,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_dat
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read and write share one block so a same-address access returns old data.
    always_ff @(posedge clk) begin
        rd_dat <= mem[rd_addr];
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

endmodule

// File: rtl/line_buf_3x3.sv
// Two-line buffer producing a 3x3 luma window around each active pixel.
// Latency: 2 cycles from y_i/dv_i/hs_i/vs_i to win_o/dv_o/hs_o/vs_o.
// Backpressure: none; streams at pixel rate, window holds while dv_o=0.
//
// Ports: clk, rst_n (async active-low); dv_i/hs_i/vs_i/y_i luma stream in;
// dv_o/hs_o/vs_o delayed controls; win_o 9 taps (k=r*3+c, r=0 oldest row,
// c=0 oldest column); line_len_o last completed line length (sat 4095);
// ovf_o sticky "line longer than MAX_WIDTH" (MAX_WIDTH must stay below 4096).
module line_buf_3x3
    import line_buf_3x3_pkg::*;
#(
    parameter int MAX_WIDTH = LB_MAX_WIDTH,
    parameter int DATA_W    = LB_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    input  logic [DATA_W-1:0]     y_i,
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic [9*DATA_W-1:0]   win_o,
    output logic [LINE_LEN_W-1:0] line_len_o,
    output logic                  ovf_o
);

    localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [LINE_LEN_W-1:0] MAX_W_C = LINE_LEN_W'(MAX_WIDTH);

    // Line FSM and counters
    line_state_t           state;
    line_state_t           state_nxt;
    logic                  dv_prev;
    logic                  vs_prev;
    logic [LINE_LEN_W-1:0] col_cnt;
    logic [1:0]            row_cnt;
    logic [LINE_LEN_W-1:0] line_len_q;
    logic                  ovf_q;

    logic                  dv_rise;
    logic                  vs_rise;
    logic                  line_end;
    logic                  pix_act;
    logic [LINE_LEN_W-1:0] pix_x;
    logic                  pix_ovf;
    s1_ctrl_t              s1_nxt;

    // Pipeline
    s1_ctrl_t              s1_ctrl;
    logic [AW-1:0]         s1_addr;
    logic [DATA_W-1:0]     s1_pix;
    logic [DATA_W-1:0]     rd_a;
    logic [DATA_W-1:0]     rd_b;
    logic [8:0][DATA_W-1:0] win_q;
    logic                  dv_q;
    logic [1:0]            hs_d;
    logic [1:0]            vs_d;

    always_comb begin
        dv_rise   = dv_i & ~dv_prev;
        vs_rise   = vs_i & ~vs_prev;
        state_nxt = state;
        case (state)
            BLANK:   if (dv_rise) state_nxt = ACTIVE;
            ACTIVE:  if (!dv_i && dv_prev) state_nxt = BLANK;
            default: state_nxt = BLANK;
        endcase
        line_end = (state == ACTIVE) && (state_nxt == BLANK);
        pix_act  = dv_i && (state_nxt == ACTIVE);
        // Entering ACTIVE restarts the column; otherwise col_cnt is the next x.
        pix_x    = (state == BLANK) ? '0 : col_cnt;
        pix_ovf  = (pix_x >= MAX_W_C);

        s1_nxt.vld     = pix_act;
        s1_nxt.first   = (pix_x == '0);
        s1_nxt.wr_en   = pix_act & ~pix_ovf;
        s1_nxt.mask_r1 = (row_cnt == 2'd0) | pix_ovf;
        s1_nxt.mask_r0 = (row_cnt != 2'd2) | pix_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK;
            dv_prev    <= 1'b1;   // a line in progress at release is not a rising edge
            vs_prev    <= 1'b0;
            col_cnt    <= '0;
            row_cnt    <= 2'd0;
            line_len_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state   <= state_nxt;
            dv_prev <= dv_i;
            vs_prev <= vs_i;
            if (pix_act) begin
                col_cnt <= sat_inc(pix_x);
            end
            if (line_end) begin
                line_len_q <= col_cnt;
            end
            // A frame start overrides a line end landing on the same cycle.
            if (vs_rise) begin
                row_cnt <= 2'd0;
            end else if (line_end && (row_cnt != 2'd2)) begin
                row_cnt <= row_cnt + 2'd1;
            end
            if (pix_act && pix_ovf) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Row y-1 in A; A's old word moves to B (row y-2) one cycle after the read.
    line_ram #(.DEPTH(MAX_WIDTH), .DATA_W(DATA_W)) u_ram_a (
        .clk     (clk),
        .rd_addr (pix_x[AW-1:0]),
        .rd_dat  (rd_a),
        .wr_en   (s1_ctrl.wr_en),
        .wr_addr (s1_addr),
        .wr_dat  (s1_pix)
    );

    line_ram #(.DEPTH(MAX_WIDTH), .DATA_W(DATA_W)) u_ram_b (
        .clk     (clk),
        .rd_addr (pix_x[AW-1:0]),
        .rd_dat  (rd_b),
        .wr_en   (s1_ctrl.wr_en),
        .wr_addr (s1_addr),
        .wr_dat  (rd_a)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ctrl <= '0;
            s1_addr <= '0;
            s1_pix  <= '0;
        end else begin
            s1_ctrl <= s1_nxt;
            s1_addr <= pix_x[AW-1:0];
            s1_pix  <= y_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
            dv_q  <= 1'b0;
            hs_d  <= 2'b00;
            vs_d  <= 2'b00;
        end else begin
            hs_d <= {hs_d[0], hs_i};
            vs_d <= {vs_d[0], vs_i};
            dv_q <= s1_ctrl.vld;
            if (s1_ctrl.vld) begin
                // Older columns shift left; a new line starts with them cleared.
                win_q[TAP_R0C0] <= s1_ctrl.first ? '0 : win_q[TAP_R0C1];
                win_q[TAP_R1C0] <= s1_ctrl.first ? '0 : win_q[TAP_R1C1];
                win_q[TAP_R2C0] <= s1_ctrl.first ? '0 : win_q[TAP_R2C1];
                win_q[TAP_R0C1] <= s1_ctrl.first ? '0 : win_q[TAP_R0C2];
                win_q[TAP_R1C1] <= s1_ctrl.first ? '0 : win_q[TAP_R1C2];
                win_q[TAP_R2C1] <= s1_ctrl.first ? '0 : win_q[TAP_R2C2];
                win_q[TAP_R0C2] <= s1_ctrl.mask_r0 ? '0 : rd_b;
                win_q[TAP_R1C2] <= s1_ctrl.mask_r1 ? '0 : rd_a;
                win_q[TAP_R2C2] <= s1_pix;
            end
        end
    end

    assign win_o      = win_q;
    assign dv_o       = dv_q;
    assign hs_o       = hs_d[1];
    assign vs_o       = vs_d[1];
    assign line_len_o = line_len_q;
    assign ovf_o      = ovf_q;

endmodule

// File: tb/tb_line_buf_3x3.sv
// Bench for line_buf_3x3: scoreboard of expected windows plus per-cycle
// control-delay checks, directed frame/line cases then random video.
// MAX_WIDTH is 8 so line overflow is reachable with short lines.
module tb_line_buf_3x3;

    localparam int MAXW = 8;
    localparam int DW   = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            dv_i = 1'b0;
    logic            hs_i = 1'b0;
    logic            vs_i = 1'b0;
    logic [DW-1:0]   y_i = '0;
    logic            dv_o;
    logic            hs_o;
    logic            vs_o;
    logic [9*DW-1:0] win_o;
    logic [11:0]     line_len_o;
    logic            ovf_o;

    line_buf_3x3 #(.MAX_WIDTH(MAXW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dv_i       (dv_i),
        .hs_i       (hs_i),
        .vs_i       (vs_i),
        .y_i        (y_i),
        .dv_o       (dv_o),
        .hs_o       (hs_o),
        .vs_o       (vs_o),
        .win_o      (win_o),
        .line_len_o (line_len_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] win;
        int          tag;
    } exp_t;

    typedef struct packed {
        logic dv;
        logic hs;
        logic vs;
    } ctl_t;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t        sb[$];
    ctl_t        pipe0, pipe1;
    logic [71:0] last_win;
    logic [71:0] snap [0:7];

    // Reference model state
    logic [7:0] mem_a [0:MAXW-1];
    logic [7:0] mem_b [0:MAXW-1];
    logic [7:0] cur   [0:4095];
    logic [7:0] up1   [0:4095];
    logic [7:0] up2   [0:4095];
    logic       m_prev_dv, m_prev_vs, m_active, m_ovf;
    int         m_col, m_rows, m_len;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_prev_dv = 1'b1;
        m_prev_vs = 1'b0;
        m_active  = 1'b0;
        m_ovf     = 1'b0;
        m_col     = 0;
        m_rows    = 0;
        m_len     = 0;
        pipe0     = '0;
        pipe1     = '0;
        last_win  = '0;
        sb.delete();
    endtask

    // Model one input cycle, queue expectations, then drive the DUT.
    task automatic drive(input logic dv, input logic hs, input logic vs,
                         input logic [7:0] y, input int tag);
        int          rows_now;
        int          x;
        logic        rise, fall, vrise, acc;
        logic [7:0]  a, b;
        logic [71:0] w;
        exp_t        e;
        rows_now = m_rows;
        rise  = dv & ~m_prev_dv;
        fall  = ~dv & m_prev_dv;
        vrise = vs & ~m_prev_vs;
        if (!m_active && rise) begin
            m_active = 1'b1;
            m_col    = 0;
        end else if (m_active && fall) begin
            m_active = 1'b0;
            m_len    = m_col;
            if (m_rows < 2) m_rows++;
        end
        if (vrise) m_rows = 0;
        acc = dv & m_active;
        if (acc) begin
            x = m_col;
            cur[x] = y;
            if (x < MAXW) begin
                a = mem_a[x];
                b = mem_b[x];
                mem_b[x] = a;
                mem_a[x] = y;
                up1[x] = (rows_now >= 1) ? a : 8'h00;
                up2[x] = (rows_now == 2) ? b : 8'h00;
            end else begin
                up1[x] = 8'h00;
                up2[x] = 8'h00;
                m_ovf  = 1'b1;
            end
            w = '0;
            for (int c = 0; c < 3; c++) begin
                int xc;
                xc = x - 2 + c;
                if (xc >= 0) begin
                    w[c*8 +: 8]       = up2[xc];
                    w[(3 + c)*8 +: 8] = up1[xc];
                    w[(6 + c)*8 +: 8] = cur[xc];
                end
            end
            e.win = w;
            e.tag = tag;
            sb.push_back(e);
            if (m_col < 4095) m_col++;
        end
        pipe1 = pipe0;
        pipe0 = '{dv: acc, hs: hs, vs: vs};
        m_prev_dv = dv;
        m_prev_vs = vs;
        dv_i = dv;
        hs_i = hs;
        vs_i = vs;
        y_i  = y;
    endtask

    task automatic monitor();
        exp_t e;
        chk("dv_o", dv_o, pipe1.dv);
        chk("hs_o", hs_o, pipe1.hs);
        chk("vs_o", vs_o, pipe1.vs);
        if (dv_o) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("win", win_o, e.win);
                last_win = e.win;
                if (e.tag != 0) snap[e.tag] = win_o;
            end
        end else begin
            chk("win_hold", win_o, last_win);
        end
    endtask

    task automatic tick(input logic dv, input logic hs, input logic vs,
                        input logic [7:0] y, input int tag);
        @(negedge clk);
        monitor();
        drive(dv, hs, vs, y, tag);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_win", win_o, '0);
        chk("rst_dv", dv_o, 1'b0);
        chk("rst_hs", hs_o, 1'b0);
        chk("rst_vs", vs_o, 1'b0);
        chk("rst_len", line_len_o, '0);
        chk("rst_ovf", ovf_o, 1'b0);
    endtask

    // Reset asserted between edges; released with dv_i held at dv_hold.
    task automatic do_reset(input logic dv_hold);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        model_reset();
        rst_n = 1'b1;
        drive(dv_hold, 1'b0, 1'b0, 8'h00, 0);
    endtask

    task automatic vs_pulse();
        tick(1'b0, 1'b0, 1'b1, 8'h00, 0);
        tick(1'b0, 1'b0, 1'b1, 8'h00, 0);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 0);
    endtask

    task automatic send_line(input int w, input int base, input int tag_x,
                             input int tag, input logic vs_at_fall);
        for (int c = 0; c < w; c++)
            tick(1'b1, 1'b0, 1'b0, 8'(base + c), (c == tag_x) ? tag : 0);
        tick(1'b0, 1'b1, vs_at_fall, 8'h00, 0);
        tick(1'b0, 1'b1, 1'b0, 8'h00, 0);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 0);
    endtask

    initial begin
        logic [71:0] exp_l3x2;
        logic [71:0] exp_single;
        logic [71:0] s;
        exp_l3x2   = 72'h22_21_20_12_11_10_02_01_00;
        exp_single = {8'h55, 64'h0};
        for (int i = 0; i < MAXW; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
        end
        for (int i = 0; i < 8; i++) snap[i] = '1;
        model_reset();

        // Power-on reset
        do_reset(1'b0);

        // Three lines of width 4, y = 16*row + col
        vs_pulse();
        send_line(4, 0, -1, 0, 1'b0);
        send_line(4, 16, -1, 0, 1'b0);
        send_line(4, 32, 2, 1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 0);
        chk("l3x2_window", snap[1], exp_l3x2);
        chk("line_len_4", line_len_o, 12'd4);
        chk("ovf_clear", ovf_o, 1'b0);

        // Single pixel as the first pixel of a frame
        vs_pulse();
        send_line(1, 8'h55, 0, 3, 1'b0);
        chk("single_pixel", snap[3], exp_single);
        chk("line_len_1", line_len_o, 12'd1);

        // Overflow: two lines of 10 pixels with MAX_WIDTH 8
        vs_pulse();
        send_line(10, 8'h40, -1, 0, 1'b0);
        chk("ovf_set", ovf_o, 1'b1);
        chk("line_len_10", line_len_o, 12'd10);
        send_line(10, 8'h80, 9, 4, 1'b0);
        s = snap[4];
        chk("ovf_upper_taps", {s[47:40], s[39:32], s[23:16], s[15:8]}, 32'h0);
        chk("ovf_cur_tap", s[71:64], 8'h89);
        chk("ovf_col7_up1", s[31:24], 8'h47);

        // vs rise on the same cycle as the dv fall
        send_line(5, 8'h60, -1, 0, 1'b1);
        chk("line_len_5", line_len_o, 12'd5);
        send_line(3, 8'h70, 2, 5, 1'b0);
        s = snap[5];
        chk("vs_clear_rows", s[47:0], 48'h0);
        chk("vs_clear_cur", s[71:48], 24'h727170);

        // Reset mid-line, released while the line is still active
        tick(1'b1, 1'b0, 1'b0, 8'h01, 0);
        tick(1'b1, 1'b0, 1'b0, 8'h02, 0);
        tick(1'b1, 1'b0, 1'b0, 8'h03, 0);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 8'(8'h10 + i), 0);
        tick(1'b0, 1'b0, 1'b0, 8'h00, 0);
        send_line(4, 8'h20, -1, 0, 1'b0);
        send_line(4, 8'h30, -1, 0, 1'b0);
        send_line(4, 8'h38, -1, 0, 1'b0);

        // Random video
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 19) == 0), 8'($urandom_range(0, 255)), 0);
        end
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 8'h00, 0);
        chk("line_len_model", line_len_o, 12'(m_len));
        chk("ovf_model", ovf_o, m_ovf);
        chk("sb_drained", 72'(sb.size()), 72'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
